// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS core. It holds the control FSM
// state encoding, the opcode and funct constants, the ALU operation encoding,
// the datapath mux-select encodings, and the control-word struct that the
// controller hands to the datapath. It also provides a sign-extension helper.
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIEX = 4'd8,
      S_ADDIWB = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_ctrl_e;

   // Second ALU operand: B register, constant 4, immediate, immediate*4.
   typedef enum logic [1:0] {
      SRCB_B      = 2'd0,
      SRCB_FOUR   = 2'd1,
      SRCB_IMM    = 2'd2,
      SRCB_IMM_SH = 2'd3
   } srcb_e;

   // Next-PC source: live ALU result, latched ALUOut, jump target.
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1,
      PCSRC_JUMP   = 2'd2
   } pcsrc_e;

   typedef struct packed {
      logic      pc_we;       // unconditional PC load
      logic      branch;      // PC load when ALU result is zero
      pcsrc_e    pc_src;
      logic      ir_we;
      logic      ab_we;
      logic      mdr_we;
      logic      aluout_we;
      logic      rf_we;
      logic      reg_dst_rd;  // 1: write rd, 0: write rt
      logic      mem_to_reg;  // 1: write MDR, 0: write ALUOut
      logic      iord;        // 1: address = ALUOut, 0: address = PC
      logic      mem_write;
      logic      srca_a;      // 1: operand A register, 0: PC
      srcb_e     srcb;
      alu_ctrl_e alu_ctrl;
   } ctrl_t;

   function automatic logic [31:0] sign_ext(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mips_controller.sv
// -----------------------------------------------------------------------------
// mips_controller
// Moore control FSM of the multicycle MIPS core plus the R-type ALU decoder.
// Every control output is a function of the current state and the latched
// instruction fields only.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (forces FETCH)
//   op_i            IR[31:26]
//   funct_i         IR[5:0]
//   ctrl_o          control word for the datapath (selects and enables)
// -----------------------------------------------------------------------------
module mips_controller
   import mips_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output ctrl_t      ctrl_o
);

   state_e    state_q;
   state_e    state_d;
   alu_ctrl_e alu_fn_s;
   logic      funct_ok_s;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // R-type funct decode; unknown functs compute harmlessly but never write back.
   always_comb begin
      alu_fn_s   = ALU_ADD;
      funct_ok_s = 1'b1;
      case (funct_i)
         FN_ADD:  alu_fn_s = ALU_ADD;
         FN_SUB:  alu_fn_s = ALU_SUB;
         FN_AND:  alu_fn_s = ALU_AND;
         FN_OR:   alu_fn_s = ALU_OR;
         FN_SLT:  alu_fn_s = ALU_SLT;
         default: begin
            alu_fn_s   = ALU_ADD;
            funct_ok_s = 1'b0;
         end
      endcase
   end

   // Next-state and control-word decode.
   always_comb begin
      state_d = state_q;
      ctrl_o  = '0;
      case (state_q)
         S_FETCH: begin
            ctrl_o.srca_a   = 1'b0;
            ctrl_o.srcb     = SRCB_FOUR;
            ctrl_o.alu_ctrl = ALU_ADD;
            ctrl_o.pc_src   = PCSRC_ALU;
            ctrl_o.pc_we    = 1'b1;
            ctrl_o.ir_we    = 1'b1;
            state_d         = S_DECODE;
         end
         S_DECODE: begin
            // Branch target precomputed from the already-incremented PC.
            ctrl_o.srca_a    = 1'b0;
            ctrl_o.srcb      = SRCB_IMM_SH;
            ctrl_o.alu_ctrl  = ALU_ADD;
            ctrl_o.aluout_we = 1'b1;
            ctrl_o.ab_we     = 1'b1;
            case (op_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ctrl_o.srca_a    = 1'b1;
            ctrl_o.srcb      = SRCB_IMM;
            ctrl_o.alu_ctrl  = ALU_ADD;
            ctrl_o.aluout_we = 1'b1;
            if (op_i == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMRD: begin
            ctrl_o.iord   = 1'b1;
            ctrl_o.mdr_we = 1'b1;
            state_d       = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl_o.rf_we      = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_dst_rd = 1'b0;
            state_d           = S_FETCH;
         end
         S_MEMWR: begin
            ctrl_o.iord      = 1'b1;
            ctrl_o.mem_write = 1'b1;
            state_d          = S_FETCH;
         end
         S_EXEC: begin
            ctrl_o.srca_a    = 1'b1;
            ctrl_o.srcb      = SRCB_B;
            ctrl_o.alu_ctrl  = alu_fn_s;
            ctrl_o.aluout_we = 1'b1;
            state_d          = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl_o.rf_we      = funct_ok_s;
            ctrl_o.reg_dst_rd = 1'b1;
            ctrl_o.mem_to_reg = 1'b0;
            state_d           = S_FETCH;
         end
         S_ADDIEX: begin
            ctrl_o.srca_a    = 1'b1;
            ctrl_o.srcb      = SRCB_IMM;
            ctrl_o.alu_ctrl  = ALU_ADD;
            ctrl_o.aluout_we = 1'b1;
            state_d          = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl_o.rf_we      = 1'b1;
            ctrl_o.reg_dst_rd = 1'b0;
            ctrl_o.mem_to_reg = 1'b0;
            state_d           = S_FETCH;
         end
         S_BRANCH: begin
            // A-B is zero exactly when the operands are equal.
            ctrl_o.srca_a   = 1'b1;
            ctrl_o.srcb     = SRCB_B;
            ctrl_o.alu_ctrl = ALU_SUB;
            ctrl_o.branch   = 1'b1;
            ctrl_o.pc_src   = PCSRC_ALUOUT;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            ctrl_o.pc_we  = 1'b1;
            ctrl_o.pc_src = PCSRC_JUMP;
            state_d       = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

endmodule

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
// 32 x 32-bit register file, two combinational read ports, one write port
// written on the rising clock edge. Register 0 always reads zero and ignores
// writes. Asynchronous active-low reset clears every register.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   ra1_i/rd1_o          read port 1 address/data
//   ra2_i/rd2_o          read port 2 address/data
//   we_i, wa_i, wd_i     write enable, address, data
// -----------------------------------------------------------------------------
module mips_regfile (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [32];

   // Register storage with write-protection of register 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   // Combinational read ports; register 0 is hard-wired to zero.
   always_comb begin
      if (ra1_i == 5'd0) begin
         rd1_o = 32'd0;
      end else begin
         rd1_o = regs_q[ra1_i];
      end
      if (ra2_i == 5'd0) begin
         rd2_o = 32'd0;
      end else begin
         rd2_o = regs_q[ra2_i];
      end
   end

endmodule

// File: rtl/mips_cpu.sv
// -----------------------------------------------------------------------------
// mips_cpu
// Multicycle 32-bit MIPS core with a single unified memory port. One shared
// ALU and one memory interface are sequenced by mips_controller; this module
// holds the datapath registers (PC, IR, MDR, A, B, ALUOut) and the regfile.
// Ports:
//   clk       system clock, rising-edge
//   reset     asynchronous active-low reset
//   rd        read data, combinational big-endian word at adr
//   adr       byte address: PC during fetch, ALUOut during data access
//   wd        write data (B register)
//   MemWrite  one-cycle write strobe per store
// -----------------------------------------------------------------------------
module mips_cpu
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rd,
   output logic [31:0] adr,
   output logic [31:0] wd,
   output logic        MemWrite
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluout_q, aluout_d;

   ctrl_t       ctrl_s;
   logic [31:0] rf_rd1_s;
   logic [31:0] rf_rd2_s;
   logic [4:0]  rf_wa_s;
   logic [31:0] rf_wd_s;
   logic [31:0] imm_ext_s;
   logic [31:0] srca_s;
   logic [31:0] srcb_s;
   logic [31:0] alu_y_s;
   logic        alu_zero_s;
   logic [31:0] jump_tgt_s;

   function automatic logic [31:0] alu_f(input alu_ctrl_e fn,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      logic [31:0] r;
      case (fn)
         ALU_ADD: r = x + y;
         ALU_SUB: r = x - y;
         ALU_AND: r = x & y;
         ALU_OR:  r = x | y;
         ALU_SLT: r = {31'd0, ($signed(x) < $signed(y))};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   mips_controller u_ctrl (
      .clk_i   (clk),
      .rst_ni  (reset),
      .op_i    (ir_q[31:26]),
      .funct_i (ir_q[5:0]),
      .ctrl_o  (ctrl_s)
   );

   mips_regfile u_rf (
      .clk_i  (clk),
      .rst_ni (reset),
      .ra1_i  (ir_q[25:21]),
      .ra2_i  (ir_q[20:16]),
      .rd1_o  (rf_rd1_s),
      .rd2_o  (rf_rd2_s),
      .we_i   (ctrl_s.rf_we),
      .wa_i   (rf_wa_s),
      .wd_i   (rf_wd_s)
   );

   assign imm_ext_s  = sign_ext(ir_q[15:0]);
   assign jump_tgt_s = {pc_q[31:28], ir_q[25:0], 2'b00};
   assign rf_wa_s    = ctrl_s.reg_dst_rd ? ir_q[15:11] : ir_q[20:16];
   assign rf_wd_s    = ctrl_s.mem_to_reg ? mdr_q : aluout_q;

   // Memory-side outputs depend only on state and registers, so they are stable within a cycle.
   assign adr      = ctrl_s.iord ? aluout_q : pc_q;
   assign wd       = b_q;
   assign MemWrite = ctrl_s.mem_write;

   // Shared ALU with operand selection.
   always_comb begin
      srca_s = pc_q;
      srcb_s = b_q;
      if (ctrl_s.srca_a) begin
         srca_s = a_q;
      end else begin
         srca_s = pc_q;
      end
      case (ctrl_s.srcb)
         SRCB_B:      srcb_s = b_q;
         SRCB_FOUR:   srcb_s = 32'd4;
         SRCB_IMM:    srcb_s = imm_ext_s;
         SRCB_IMM_SH: srcb_s = {imm_ext_s[29:0], 2'b00};
         default:     srcb_s = b_q;
      endcase
      alu_y_s    = alu_f(ctrl_s.alu_ctrl, srca_s, srcb_s);
      alu_zero_s = (alu_y_s == 32'd0);
   end

   // Next-state of the datapath registers; each holds unless its enable is set.
   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      if (ctrl_s.pc_we || (ctrl_s.branch && alu_zero_s)) begin
         case (ctrl_s.pc_src)
            PCSRC_ALU:    pc_d = alu_y_s;
            PCSRC_ALUOUT: pc_d = aluout_q;
            PCSRC_JUMP:   pc_d = jump_tgt_s;
            default:      pc_d = pc_q;
         endcase
      end else begin
         pc_d = pc_q;
      end
      if (ctrl_s.ir_we) begin
         ir_d = rd;
      end else begin
         ir_d = ir_q;
      end
      if (ctrl_s.mdr_we) begin
         mdr_d = rd;
      end else begin
         mdr_d = mdr_q;
      end
      if (ctrl_s.ab_we) begin
         a_d = rf_rd1_s;
         b_d = rf_rd2_s;
      end else begin
         a_d = a_q;
         b_d = b_q;
      end
      if (ctrl_s.aluout_we) begin
         aluout_d = alu_y_s;
      end else begin
         aluout_d = aluout_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= 32'd0;
         ir_q     <= 32'd0;
         mdr_q    <= 32'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         aluout_q <= 32'd0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         mdr_q    <= mdr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
      end
   end

endmodule

// File: tb/tb_mips_cpu.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu
// Directed bench for mips_cpu: a big-endian byte memory model, a preloaded
// program, and hand-computed expectations for write strobes, addresses and
// fetch addresses at fixed cycle numbers after reset release. Cycle c is
// the clock period that ends at the c-th rising edge after release.
// -----------------------------------------------------------------------------
module tb_mips_cpu;

   logic        clk_s = 1'b0;
   logic        reset_s;
   logic [31:0] rd_s;
   logic [31:0] adr_s;
   logic [31:0] wd_s;
   logic        mem_write_s;
   logic [1:0]  load_sel_s;
   logic [7:0]  mem_r [0:511];
   int          checks_r;
   int          errors_r;
   int          cyc_r;

   always #5 clk_s = ~clk_s;

   mips_cpu dut (
      .clk      (clk_s),
      .reset    (reset_s),
      .rd       (rd_s),
      .adr      (adr_s),
      .wd       (wd_s),
      .MemWrite (mem_write_s)
   );

   assign rd_s = {mem_r[adr_s[8:0]], mem_r[adr_s[8:0] + 9'd1],
                  mem_r[adr_s[8:0] + 9'd2], mem_r[adr_s[8:0] + 9'd3]};

   task automatic wr_word(input int a, input logic [31:0] w);
      mem_r[a]     <= w[31:24];
      mem_r[a + 1] <= w[23:16];
      mem_r[a + 2] <= w[15:8];
      mem_r[a + 3] <= w[7:0];
   endtask

   // Memory model: image loads on request, otherwise store on MemWrite.
   always @(posedge clk_s) begin
      if (load_sel_s == 2'd1) begin
         for (int i = 0; i < 512; i++) mem_r[i] <= 8'h00;
         wr_word(0,   32'h8C010020); // lw  $1,32($0)
         wr_word(4,   32'hAC010024); // sw  $1,36($0)
         wr_word(8,   32'h8C020028); // lw  $2,40($0)
         wr_word(12,  32'h20430001); // addi $3,$2,1
         wr_word(16,  32'hAC030040); // sw  $3,64($0)
         wr_word(20,  32'h08000013); // j   0x13 -> 76
         wr_word(32,  32'h0000000F);
         wr_word(40,  32'h0000000C);
         wr_word(76,  32'h00222020); // add $4,$1,$2
         wr_word(80,  32'hAC04002C); // sw  $4,44($0)
         wr_word(84,  32'h10210002); // beq $1,$1,2 (taken -> 96)
         wr_word(88,  32'hAC0100C8); // skipped
         wr_word(92,  32'hAC0100C8); // skipped
         wr_word(96,  32'h10220002); // beq $1,$2,2 (not taken)
         wr_word(100, 32'h2005FFFF); // addi $5,$0,-1
         wr_word(104, 32'h20060001); // addi $6,$0,1
         wr_word(108, 32'h00A6382A); // slt $7,$5,$6
         wr_word(112, 32'h00064022); // sub $8,$0,$6
         wr_word(116, 32'h00C60020); // add $0,$6,$6
         wr_word(120, 32'hAC070030); // sw  $7,48($0)
         wr_word(124, 32'hAC080034); // sw  $8,52($0)
         wr_word(128, 32'hAC000038); // sw  $0,56($0)
         wr_word(132, 32'hAC01003C); // sw  $1,60($0) (interrupted by reset)
      end else if (load_sel_s == 2'd2) begin
         wr_word(0, 32'hAC010064);   // sw $1,100($0)
         wr_word(4, 32'hAC040068);   // sw $4,104($0)
         wr_word(8, 32'hAC03006C);   // sw $3,108($0)
      end else if (mem_write_s) begin
         mem_r[adr_s[8:0]]         <= wd_s[31:24];
         mem_r[adr_s[8:0] + 9'd1]  <= wd_s[23:16];
         mem_r[adr_s[8:0] + 9'd2]  <= wd_s[15:8];
         mem_r[adr_s[8:0] + 9'd3]  <= wd_s[7:0];
      end
   end

   function automatic logic [31:0] mem_word(input int a);
      return {mem_r[a], mem_r[a + 1], mem_r[a + 2], mem_r[a + 3]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_r++;
      assert (obs === exp) else begin
         errors_r++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to cycle c and sample 2 time units after its opening edge.
   task automatic goto_cycle(input int c);
      while (cyc_r < c) begin
         @(posedge clk_s);
         #2;
         cyc_r++;
      end
   endtask

   task automatic chk_store(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_we"},  {31'd0, mem_write_s}, 32'd1);
      chk({tag, "_adr"}, adr_s, a);
      chk({tag, "_wd"},  wd_s, d);
   endtask

   initial begin
      checks_r   = 0;
      errors_r   = 0;
      cyc_r      = 0;
      reset_s    = 1'b0;
      load_sel_s = 2'd1;
      @(posedge clk_s);
      #2;
      load_sel_s = 2'd0;
      chk("rst_adr", adr_s, 32'd0);
      chk("rst_wd",  wd_s, 32'd0);
      chk("rst_we",  {31'd0, mem_write_s}, 32'd0);
      @(posedge clk_s);
      #2;
      reset_s = 1'b1;
      cyc_r   = 1;

      chk("fetch0_adr", adr_s, 32'd0);
      goto_cycle(8);
      chk("c8_we_low", {31'd0, mem_write_s}, 32'd0);
      goto_cycle(9);
      chk_store("sw1", 32'd36, 32'd15);
      goto_cycle(10);
      chk("c10_we_low", {31'd0, mem_write_s}, 32'd0);
      goto_cycle(22);
      chk_store("sw3", 32'd64, 32'd13);
      goto_cycle(23);
      chk("fetch_j", adr_s, 32'd20);
      goto_cycle(26);
      chk("fetch_jtgt", adr_s, 32'd76);
      goto_cycle(33);
      chk_store("sw4", 32'd44, 32'd27);
      goto_cycle(34);
      chk("fetch_beq1", adr_s, 32'd84);
      goto_cycle(37);
      chk("beq_taken", adr_s, 32'd96);
      goto_cycle(40);
      chk("beq_not_taken", adr_s, 32'd100);
      goto_cycle(63);
      chk_store("slt", 32'd48, 32'd1);
      goto_cycle(67);
      chk_store("sub_neg", 32'd52, 32'hFFFFFFFF);
      goto_cycle(71);
      chk_store("r0_zero", 32'd56, 32'd0);
      goto_cycle(75);
      chk("memwr_pre_we", {31'd0, mem_write_s}, 32'd1);
      chk("memwr_pre_adr", adr_s, 32'd60);

      // Reset in the middle of a store.
      #1;
      reset_s = 1'b0;
      #1;
      chk("midrst_we",  {31'd0, mem_write_s}, 32'd0);
      chk("midrst_adr", adr_s, 32'd0);
      chk("midrst_wd",  wd_s, 32'd0);
      load_sel_s = 2'd2;
      @(posedge clk_s);
      #2;
      load_sel_s = 2'd0;
      chk("mem36", mem_word(36), 32'd15);
      chk("mem64", mem_word(64), 32'd13);
      chk("mem44", mem_word(44), 32'd27);
      chk("mem60_untouched", mem_word(60), 32'd0);
      @(posedge clk_s);
      #2;
      reset_s = 1'b1;
      cyc_r   = 1;

      chk("post_rst_fetch", adr_s, 32'd0);
      goto_cycle(4);
      chk_store("post_r1", 32'd100, 32'd0);
      goto_cycle(8);
      chk("post_r4_adr", adr_s, 32'd104);
      chk("post_r4_wd",  wd_s, 32'd0);
      goto_cycle(12);
      chk("post_r3_adr", adr_s, 32'd108);
      chk("post_r3_wd",  wd_s, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
      $finish;
   end

endmodule
